// File: rtl/seven_seg_capture.sv
// Snoops a multiplexed 7-segment bus and recovers the hex nibble shown on each digit.
// Define SEVEN_SEG_CAPTURE_ACTIVE_LOW_EN to snoop common-anode (active-low) displays.
module seven_seg_capture #(
   parameter int DIGITS     = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [6:0]            seg_in,
   input  logic [DIGITS-1:0]     an_in,
   output logic [4*DIGITS-1:0]   digit_out,
   output logic [DIGITS-1:0]     digit_vld,
   output logic                  frame_vld,
   output logic                  err,
   output logic [1:0]            err_code
);

   localparam int         SW         = 7 + DIGITS;
   localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYC);

   localparam logic [1:0] ST_WAIT   = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_HELD   = 2'd2;

   logic [6:0]        w_segIn;
   logic [DIGITS-1:0] w_anIn;

`ifdef SEVEN_SEG_CAPTURE_ACTIVE_LOW_EN
   assign w_segIn = ~seg_in;
   assign w_anIn  = ~an_in;
`else
   assign w_segIn = seg_in;
   assign w_anIn  = an_in;
`endif

   logic [SW-1:0]     r_samp;
   logic [SW-1:0]     r_prev;
   logic [1:0]        r_state;
   logic [7:0]        r_cnt;
   logic [DIGITS-1:0] r_mask;

   logic [6:0]        w_sampSeg;
   logic [DIGITS-1:0] w_sampAn;
   logic              w_same;
   logic              w_legal;
   logic [3:0]        w_nib;
   logic [1:0]        w_nextState;
   logic [7:0]        w_nextCnt;
   logic [7:0]        w_cntInc;
   logic              w_capture;
   logic              w_capOneHot;
   logic              w_capMulti;
   logic [DIGITS-1:0] w_capMask;

   assign w_sampSeg = r_samp[SW-1:DIGITS];
   assign w_sampAn  = r_samp[DIGITS-1:0];
   assign w_same    = (r_samp == r_prev);
   assign w_cntInc  = r_cnt + 8'd1;

   always_comb begin
      w_legal = 1'b1;
      w_nib   = 4'h0;
      case (w_sampSeg)
         7'b1111110: w_nib = 4'h0;
         7'b0110000: w_nib = 4'h1;
         7'b1101101: w_nib = 4'h2;
         7'b1111001: w_nib = 4'h3;
         7'b0110011: w_nib = 4'h4;
         7'b1011011: w_nib = 4'h5;
         7'b1011111: w_nib = 4'h6;
         7'b1110000: w_nib = 4'h7;
         7'b1111111: w_nib = 4'h8;
         7'b1111011: w_nib = 4'h9;
         7'b1110111: w_nib = 4'hA;
         7'b0011111: w_nib = 4'hB;
         7'b1001110: w_nib = 4'hC;
         7'b0111101: w_nib = 4'hD;
         7'b1001111: w_nib = 4'hE;
         7'b1000111: w_nib = 4'hF;
         default:    w_legal = 1'b0;
      endcase
   end

   // The first match already represents two identical samples, so a two-cycle
   // stability requirement captures straight out of WAIT.
   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      w_capture   = 1'b0;
      case (r_state)
         ST_WAIT: begin
            if (w_same) begin
               if (STABLE_LIM <= 8'd2) begin
                  w_capture   = 1'b1;
                  w_nextState = ST_HELD;
                  w_nextCnt   = STABLE_LIM;
               end else begin
                  w_nextState = ST_SETTLE;
                  w_nextCnt   = 8'd2;
               end
            end
         end
         ST_SETTLE: begin
            if (!w_same) begin
               w_nextState = ST_WAIT;
               w_nextCnt   = 8'd0;
            end else begin
               w_nextCnt = w_cntInc;
               if (w_cntInc == STABLE_LIM) begin
                  w_capture   = 1'b1;
                  w_nextState = ST_HELD;
               end
            end
         end
         ST_HELD: begin
            if (!w_same) begin
               w_nextState = ST_WAIT;
               w_nextCnt   = 8'd0;
            end
         end
         default: begin
            w_nextState = ST_WAIT;
            w_nextCnt   = 8'd0;
         end
      endcase
   end

   assign w_capOneHot = w_capture & $onehot(w_sampAn);
   assign w_capMulti  = w_capture & (w_sampAn != '0) & ~$onehot(w_sampAn);
   assign w_capMask   = w_capOneHot ? w_sampAn : '0;

   // A capture landing in the frame-complete cycle seeds the next frame's mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_samp    <= '0;
         r_prev    <= '0;
         r_state   <= ST_WAIT;
         r_cnt     <= 8'd0;
         r_mask    <= '0;
         digit_out <= '0;
         digit_vld <= '0;
         frame_vld <= 1'b0;
         err       <= 1'b0;
         err_code  <= 2'b00;
      end else begin
         r_samp  <= {w_segIn, w_anIn};
         r_prev  <= r_samp;
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
         err     <= 1'b0;
         if (w_capMulti) begin
            err      <= 1'b1;
            err_code <= 2'b10;
         end
         for (int k = 0; k < DIGITS; k++) begin
            if (w_capOneHot && w_sampAn[k]) begin
               if (w_legal) begin
                  digit_out[4*k +: 4] <= w_nib;
                  digit_vld[k]        <= 1'b1;
               end else begin
                  digit_vld[k] <= 1'b0;
                  err          <= 1'b1;
                  err_code     <= 2'b01;
               end
            end
         end
         if (r_mask == '1) begin
            frame_vld <= 1'b1;
            r_mask    <= w_capMask;
         end else begin
            frame_vld <= 1'b0;
            r_mask    <= r_mask | w_capMask;
         end
      end
   end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture (DIGITS=4, STABLE_CYC=4).
// Stimulus is given in logical (active-high) terms and inverted when SEVEN_SEG_CAPTURE_ACTIVE_LOW_EN is set.
module tb_seven_seg_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  seg_in;
   logic [3:0]  an_in;
   logic [15:0] digit_out;
   logic [3:0]  digit_vld;
   logic        frame_vld;
   logic        err;
   logic [1:0]  err_code;

   int total = 0;
   int bad   = 0;
   int errPulses;

   seven_seg_capture #(.DIGITS(4), .STABLE_CYC(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .seg_in    (seg_in),
      .an_in     (an_in),
      .digit_out (digit_out),
      .digit_vld (digit_vld),
      .frame_vld (frame_vld),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   task automatic stepCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [6:0] seg, input logic [3:0] an, input int cycles);
`ifdef SEVEN_SEG_CAPTURE_ACTIVE_LOW_EN
      seg_in = ~seg;
      an_in  = ~an;
`else
      seg_in = seg;
      an_in  = an;
`endif
      stepCycles(cycles);
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      // Reset with garbage (multiple digit selects) on the pins.
      rst = 1'b1;
      applyStimulus(7'h55, 4'b0101, 3);
      checkOutput("rstDigitOut", 32'(digit_out), 32'h0000);
      checkOutput("rstDigitVld", 32'(digit_vld), 32'h0);
      checkOutput("rstFrameVld", 32'(frame_vld), 32'h0);
      checkOutput("rstErr", 32'(err), 32'h0);
      checkOutput("rstErrCode", 32'(err_code), 32'h0);
      rst = 1'b0;
      stepCycles(4);
      checkOutput("earlyErr", 32'(err), 32'h0);
      checkOutput("earlyErrCode", 32'(err_code), 32'h0);
      stepCycles(1);
      checkOutput("firstCapErr", 32'(err), 32'h1);
      checkOutput("firstCapErrCode", 32'(err_code), 32'h2);
      stepCycles(1);
      checkOutput("errPulseEnds", 32'(err), 32'h0);

      // Scan 1, 2, A, F across digits 0..3.
      applyStimulus(7'h30, 4'b0001, 6);
      checkOutput("scanD0Out", 32'(digit_out), 32'h0001);
      checkOutput("scanD0Vld", 32'(digit_vld), 32'h1);
      applyStimulus(7'h6D, 4'b0010, 6);
      applyStimulus(7'h77, 4'b0100, 6);
      checkOutput("scanD2Out", 32'(digit_out), 32'h0A21);
      checkOutput("scanD2Frame", 32'(frame_vld), 32'h0);
      applyStimulus(7'h47, 4'b1000, 5);
      checkOutput("scanD3Out", 32'(digit_out), 32'hFA21);
      checkOutput("scanD3Vld", 32'(digit_vld), 32'hF);
      checkOutput("frameNotYet", 32'(frame_vld), 32'h0);
      stepCycles(1);
      checkOutput("framePulse", 32'(frame_vld), 32'h1);
      stepCycles(1);
      checkOutput("framePulseEnds", 32'(frame_vld), 32'h0);

      // Glitch: 3 stable cycles must not capture; 4 must capture on the 5th edge.
      applyStimulus(7'h5B, 4'b0010, 3);
      checkOutput("glitchNoCap", 32'(digit_out), 32'hFA21);
      applyStimulus(7'h70, 4'b0010, 4);
      checkOutput("stableEdge4", 32'(digit_out), 32'hFA21);
      stepCycles(1);
      checkOutput("stableEdge5", 32'(digit_out), 32'hFA71);

      // Two digit selects at once: one error pulse, no digit update.
      errPulses = 0;
      applyStimulus(7'h7F, 4'b0011, 0);
      for (int i = 0; i < 10; i++) begin
         stepCycles(1);
         if (err === 1'b1) errPulses++;
      end
      checkOutput("multiErrPulses", 32'(errPulses), 32'd1);
      checkOutput("multiErrCode", 32'(err_code), 32'h2);
      checkOutput("multiDigitOut", 32'(digit_out), 32'hFA71);

      // Illegal pattern on digit 2 still counts toward the frame.
      applyStimulus(7'h01, 4'b0100, 5);
      checkOutput("illegalErr", 32'(err), 32'h1);
      checkOutput("illegalErrCode", 32'(err_code), 32'h1);
      checkOutput("illegalVld", 32'(digit_vld), 32'hB);
      checkOutput("illegalOut", 32'(digit_out), 32'hFA71);
      stepCycles(1);
      applyStimulus(7'h7E, 4'b0001, 6);
      checkOutput("frame2D0Out", 32'(digit_out), 32'hFA70);
      checkOutput("frame2D0Frame", 32'(frame_vld), 32'h0);
      applyStimulus(7'h4E, 4'b1000, 5);
      checkOutput("frame2D3Out", 32'(digit_out), 32'hCA70);
      checkOutput("frame2Vld", 32'(digit_vld), 32'hB);
      checkOutput("frame2NotYet", 32'(frame_vld), 32'h0);
      stepCycles(1);
      checkOutput("frame2Pulse", 32'(frame_vld), 32'h1);

      // Reset in the middle of settling discards the pending capture.
      applyStimulus(7'h7B, 4'b0001, 3);
      rst = 1'b1;
      stepCycles(1);
      checkOutput("midRstOut", 32'(digit_out), 32'h0000);
      checkOutput("midRstVld", 32'(digit_vld), 32'h0);
      rst = 1'b0;
      stepCycles(4);
      checkOutput("postRstEdge4", 32'(digit_vld), 32'h0);
      stepCycles(1);
      checkOutput("postRstEdge5Vld", 32'(digit_vld), 32'h1);
      checkOutput("postRstEdge5Out", 32'(digit_out), 32'h0009);

`ifdef SEVEN_SEG_CAPTURE_ACTIVE_LOW_EN
      // Raw active-low drive: all segments low shows 8 on digit 0.
      seg_in = 7'h00;
      an_in  = 4'b1110;
      stepCycles(6);
      checkOutput("activeLowOut", 32'(digit_out[3:0]), 32'h8);
      checkOutput("activeLowVld", 32'(digit_vld[0]), 32'h1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
